// File: rtl/acc_pkg.sv
// ============================================================================
//  Module      : acc_pkg
//  Description : Shared types and default constants for the accumulator/flag
//                register stage (operation codes, FSM states, widths).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package acc_pkg;

    localparam int NUM_BITS = 8;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ADD  = 2'd1,
        SUB  = 2'd2,
        CLR  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : acc_pkg

`default_nettype wire

// File: rtl/acc_alu.sv
// ============================================================================
//  Module      : acc_alu
//  Description : Combinational next-accumulator logic. Add/sub are done one
//                bit wider than the operands so the true result is always
//                representable; overflow is a disagreement between the two
//                top bits of the widened result.
//                SATURATION_EN : clamp overflowing results instead of wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module acc_alu
    import acc_pkg::*;
#(
    parameter int NUM_BITS = acc_pkg::NUM_BITS
) (
    input  logic [NUM_BITS-1:0] acc,
    input  logic [NUM_BITS-1:0] in_data,
    input  op_e                 op,
    output logic [NUM_BITS-1:0] next_acc,
    output logic                next_v
);

`ifdef SATURATION_EN
    localparam logic [NUM_BITS-1:0] c_sat_max = {1'b0, {(NUM_BITS-1){1'b1}}};
    localparam logic [NUM_BITS-1:0] c_sat_min = {1'b1, {(NUM_BITS-1){1'b0}}};
`endif

    logic [NUM_BITS:0] w_acc_x;
    logic [NUM_BITS:0] w_data_x;
    logic [NUM_BITS:0] w_res;
    logic              w_ovf;

    // Sign-extend both operands by one bit; SUB is a direct subtraction so
    // subtracting the most negative value still yields the true result.
    assign w_acc_x  = {acc[NUM_BITS-1], acc};
    assign w_data_x = {in_data[NUM_BITS-1], in_data};

    // Select the widened result, detect overflow and form the new accumulator.
    always_comb begin
        w_res    = w_acc_x + w_data_x;
        if (op == SUB) begin
            w_res = w_acc_x - w_data_x;
        end
        w_ovf    = (w_res[NUM_BITS] != w_res[NUM_BITS-1]);
        next_acc = w_res[NUM_BITS-1:0];
        next_v   = w_ovf;
`ifdef SATURATION_EN
        // The extra top bit carries the true sign of an overflowing result.
        if (w_ovf) begin
            next_acc = w_res[NUM_BITS] ? c_sat_min : c_sat_max;
        end
`endif
        case (op)
            LOAD: begin
                next_acc = in_data;
                next_v   = 1'b0;
            end
            CLR: begin
                next_acc = '0;
                next_v   = 1'b0;
            end
            default: ;
        endcase
    end

endmodule : acc_alu

`default_nettype wire

// File: rtl/acc_flag_reg.sv
// ============================================================================
//  Module      : acc_flag_reg
//  Description : Registered accumulator stage with Z/N/P/V flags and a
//                saturating operation counter. One operand is accepted in
//                IDLE, folded in during EXEC, and the result is held in DONE
//                until downstream takes it.
//                SATURATION_EN : forwarded to acc_alu (clamp on overflow).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module acc_flag_reg
    import acc_pkg::*;
#(
    parameter int NUM_BITS = acc_pkg::NUM_BITS,
    parameter int CNT_W    = acc_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [NUM_BITS-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] acc,
    output logic                z,
    output logic                n,
    output logic                p,
    output logic                v,
    output logic [CNT_W-1:0]    count
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_e              r_state;
    state_e              w_state_nxt;
    op_e                 r_op;
    logic [NUM_BITS-1:0] r_data;
    logic [NUM_BITS-1:0] r_acc;
    logic                r_z;
    logic                r_n;
    logic                r_p;
    logic                r_v;
    logic [CNT_W-1:0]    r_count;
    logic [NUM_BITS-1:0] w_next_acc;
    logic                w_next_v;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                w_accept;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready;

    assign acc   = r_acc;
    assign z     = r_z;
    assign n     = r_n;
    assign p     = r_p;
    assign v     = r_v;
    assign count = r_count;

    acc_alu #(
        .NUM_BITS (NUM_BITS)
    ) u_alu (
        .acc      (r_acc),
        .in_data  (r_data),
        .op       (r_op),
        .next_acc (w_next_acc),
        .next_v   (w_next_v)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> EXEC on handshake, EXEC -> DONE, DONE -> IDLE on out_ready.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_nxt = EXEC;
            EXEC:                   w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Capture the operand and operation on the input handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op   <= LOAD;
            r_data <= '0;
        end else if (w_accept) begin
            r_op   <= op_e'(in_op);
            r_data <= in_data;
        end
    end

    // Counter next value: CLR restarts it, all other ops count up and stick at max.
    always_comb begin
        w_count_nxt = r_count;
        if (r_op == CLR) begin
            w_count_nxt = '0;
        end else if (r_count != c_cnt_max) begin
            w_count_nxt = r_count + 1'b1;
        end
    end

    // Accumulator, flags and counter change only on the EXEC edge, so DONE holds them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_z     <= 1'b1;
            r_n     <= 1'b0;
            r_p     <= 1'b1;
            r_v     <= 1'b0;
            r_count <= '0;
        end else if (r_state == EXEC) begin
            r_acc   <= w_next_acc;
            r_z     <= (w_next_acc == '0);
            r_n     <= w_next_acc[NUM_BITS-1];
            r_p     <= ~w_next_acc[0];
            r_v     <= w_next_v;
            r_count <= w_count_nxt;
        end
    end

endmodule : acc_flag_reg

`default_nettype wire

// File: tb/tb_acc_flag_reg.sv
// ============================================================================
//  Module      : tb_acc_flag_reg
//  Description : Directed and randomized bench for acc_flag_reg with an
//                integer reference model of the accumulator, flags and count.
//                SATURATION_EN : selects clamp vs wrap in the model as well.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_acc_flag_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] acc;
    logic       z;
    logic       n;
    logic       p;
    logic       v;
    logic [3:0] count;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state.
    int m_acc = 0;
    int m_v   = 0;
    int m_cnt = 0;

    acc_flag_reg dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .z         (z),
        .n         (n),
        .p         (p),
        .v         (v),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: true mathematical result, then wrap or clamp when out of range.
    task automatic model(input int op, input int d);
        int t;
        case (op)
            0: begin m_acc = d; m_v = 0; end
            1, 2: begin
                t = (op == 1) ? m_acc + d : m_acc - d;
                if (t > 127 || t < -128) begin
                    m_v = 1;
`ifdef SATURATION_EN
                    t = (t > 127) ? 127 : -128;
`else
                    t = ((t + 128) & 255) - 128;
`endif
                end else begin
                    m_v = 0;
                end
                m_acc = t;
            end
            default: begin m_acc = 0; m_v = 0; m_cnt = 0; end
        endcase
        if (op != 3 && m_cnt < 15) m_cnt++;
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 1);
        chk({tag, "_acc"},       int'($signed(acc)), m_acc);
        chk({tag, "_z"},         int'(z), (m_acc == 0) ? 1 : 0);
        chk({tag, "_n"},         int'(n), (m_acc < 0) ? 1 : 0);
        chk({tag, "_p"},         int'(p), ((m_acc & 1) == 0) ? 1 : 0);
        chk({tag, "_v"},         int'(v), m_v);
        chk({tag, "_count"},     int'(count), m_cnt);
    endtask

    // One full transaction starting at an IDLE sample point. During the
    // hold cycles the next op may be presented early to prove it is not taken.
    task automatic do_op(input int op, input int d, input int hold,
                         input bit pend, input int nop, input int nd);
        chk("idle_in_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_op    = op[1:0];
        in_data  = d[7:0];
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("exec_out_valid", int'(out_valid), 0);
        chk("exec_in_ready",  int'(in_ready), 0);
        model(op, d);
        @(posedge clk); #1;
        check_result("done");
        for (int i = 0; i < hold; i++) begin
            if (pend) begin
                in_valid = 1'b1;
                in_op    = nop[1:0];
                in_data  = nd[7:0];
            end
            @(posedge clk); #1;
            check_result("hold");
            chk("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_out_valid", int'(out_valid), 0);
        chk("release_in_ready",  int'(in_ready), 1);
    endtask

    initial begin
        int op;
        int d;
        logic [7:0] rb;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        chk("rst_acc", int'(acc), 0);
        chk("rst_z", int'(z), 1);
        chk("rst_n", int'(n), 0);
        chk("rst_p", int'(p), 1);
        chk("rst_v", int'(v), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // LOAD 5, ADD 3.
        do_op(0, 5, 0, 1'b0, 0, 0);
        do_op(1, 3, 0, 1'b0, 0, 0);

        // Positive overflow.
        do_op(0, 100, 0, 1'b0, 0, 0);
        do_op(1, 100, 0, 1'b0, 0, 0);

        // Negative overflow, then an exact zero.
        do_op(0, -128, 0, 1'b0, 0, 0);
        do_op(2, 1, 0, 1'b0, 0, 0);
        do_op(0, 7, 0, 1'b0, 0, 0);
        do_op(2, 7, 0, 1'b0, 0, 0);

        // Subtracting the most negative value.
        do_op(2, -128, 0, 1'b0, 0, 0);
        do_op(0, -1, 0, 1'b0, 0, 0);
        do_op(2, -128, 0, 1'b0, 0, 0);

        // Backpressure with a pending op, which must be taken after release.
        do_op(1, 2, 3, 1'b1, 1, 10);
        do_op(1, 10, 0, 1'b0, 0, 0);

        // Reset during EXEC of ADD 9 on acc=4.
        do_op(0, 4, 0, 1'b0, 0, 0);
        in_valid = 1'b1;
        in_op    = 2'd1;
        in_data  = 8'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_acc = 0; m_v = 0; m_cnt = 0;
        chk("rstexec_acc", int'(acc), 0);
        chk("rstexec_z", int'(z), 1);
        chk("rstexec_out_valid", int'(out_valid), 0);
        chk("rstexec_in_ready", int'(in_ready), 1);
        chk("rstexec_count", int'(count), 0);
        @(posedge clk); #1;
        chk("rstexec_no_output", int'(out_valid), 0);

        // Counter saturation and CLR.
        do_op(3, 0, 0, 1'b0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            do_op(1, 1, 0, 1'b0, 0, 0);
        end
        do_op(3, 0, 0, 1'b0, 0, 0);

        // Randomized ops with random backpressure.
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 9));
            op = (op < 2) ? 0 : (op < 5) ? 1 : (op < 8) ? 2 : 3;
            rb = 8'($urandom);
            d  = int'($signed(rb));
            do_op(op, d, int'($urandom_range(0, 2)), 1'b0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_acc_flag_reg

`default_nettype wire
